// File: rtl/rf_pkg.sv
// Shared types and sizes for the register-file write-back scheduler.
// No logic; imported by the interface, the scoreboard and the top level.
package rf_pkg;

   localparam int XLEN       = 32;
   localparam int NREG       = 32;
   localparam int REG_ADDR_W = 5;

   typedef enum logic {
      WB_ALU = 1'b0,
      WB_LSU = 1'b1
   } wb_src_t;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] rd;
      logic [XLEN-1:0]       dat;
   } wb_req_t;

endpackage

// File: rtl/rf_wb_sched_if.sv
// Issue, write-back producer, register-file and lookup signals of rf_wb_sched.
// Bypass operand ports exist only when RF_WB_BYPASS_EN is defined.
interface rf_wb_sched_if;
   import rf_pkg::*;

   logic                  iss_valid;
   logic [REG_ADDR_W-1:0] iss_rd;
   logic                  iss_ready;

   logic                  alu_valid;
   logic                  alu_ready;
   logic [REG_ADDR_W-1:0] alu_rd;
   logic [XLEN-1:0]       alu_data;

   logic                  lsu_valid;
   logic                  lsu_ready;
   logic [REG_ADDR_W-1:0] lsu_rd;
   logic [XLEN-1:0]       lsu_data;

   logic                  rf_regwr;
   logic [REG_ADDR_W-1:0] rf_rd;
   logic [XLEN-1:0]       rf_busw;

   logic [REG_ADDR_W-1:0] rs1;
   logic [REG_ADDR_W-1:0] rs2;
   logic                  rs1_busy;
   logic                  rs2_busy;
   logic [NREG-1:0]       busy_mask;
   logic                  wb_err;

`ifdef RF_WB_BYPASS_EN
   logic [XLEN-1:0]       rf_busa_in;
   logic [XLEN-1:0]       rf_busb_in;
   logic [XLEN-1:0]       opa;
   logic [XLEN-1:0]       opb;
`endif

   modport master (
`ifdef RF_WB_BYPASS_EN
      output rf_busa_in, rf_busb_in,
      input  opa, opb,
`endif
      output iss_valid, iss_rd,
      input  iss_ready,
      output alu_valid, alu_rd, alu_data,
      input  alu_ready,
      output lsu_valid, lsu_rd, lsu_data,
      input  lsu_ready,
      input  rf_regwr, rf_rd, rf_busw,
      output rs1, rs2,
      input  rs1_busy, rs2_busy, busy_mask, wb_err
   );

   modport slave (
`ifdef RF_WB_BYPASS_EN
      input  rf_busa_in, rf_busb_in,
      output opa, opb,
`endif
      input  iss_valid, iss_rd,
      output iss_ready,
      input  alu_valid, alu_rd, alu_data,
      output alu_ready,
      input  lsu_valid, lsu_rd, lsu_data,
      output lsu_ready,
      output rf_regwr, rf_rd, rf_busw,
      input  rs1, rs2,
      output rs1_busy, rs2_busy, busy_mask, wb_err
   );

endinterface

// File: rtl/rf_wb_sched_scoreboard.sv
// Busy-mask scoreboard: set on issue, clear on write-back, WAW stall and RAW lookups.
// Lookups are combinational from the registered mask; wb_err is sticky until reset.
module rf_scoreboard
   import rf_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  iss_valid,
   input  logic [REG_ADDR_W-1:0] iss_rd,
   output logic                  iss_ready,
   input  logic                  clr_vld,
   input  logic [REG_ADDR_W-1:0] clr_rd,
   input  logic [REG_ADDR_W-1:0] rs1,
   input  logic [REG_ADDR_W-1:0] rs2,
   output logic                  rs1_busy,
   output logic                  rs2_busy,
   output logic [NREG-1:0]       busy_mask,
   output logic                  wb_err
);

   logic [NREG-1:0] busy_q, busy_d;
   logic            wb_err_q, wb_err_d;
   logic            iss_ok;

   // Uses the pre-clear mask, so a same-cycle set/clear of one register cannot happen.
   assign iss_ok = !((iss_rd != '0) && busy_q[iss_rd]);

   always_comb begin
      busy_d = busy_q;
      if (clr_vld) begin
         busy_d[clr_rd] = 1'b0;
      end
      if (iss_valid && iss_ok && (iss_rd != '0)) begin
         busy_d[iss_rd] = 1'b1;
      end
      busy_d[0] = 1'b0;
      wb_err_d = wb_err_q | (clr_vld && (clr_rd != '0) && !busy_q[clr_rd]);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q   <= '0;
         wb_err_q <= 1'b0;
      end else begin
         busy_q   <= busy_d;
         wb_err_q <= wb_err_d;
      end
   end

   assign iss_ready = iss_ok;
   assign rs1_busy  = busy_q[rs1];
   assign rs2_busy  = busy_q[rs2];
   assign busy_mask = busy_q;
   assign wb_err    = wb_err_q;

endmodule

// File: rtl/rf_wb_sched.sv
// Round-robin ALU/LSU write-back arbiter driving a registered RF write port; rf_regwr the cycle after acceptance.
// Loser of a tie waits a cycle; RF_WB_BYPASS_EN adds operand forwarding and clears busy at acceptance.
module rf_wb_sched (
   input logic          clk,
   input logic          rst_n,
   rf_wb_sched_if.slave bus
);
   import rf_pkg::*;

   wb_src_t               last_q, last_d;
   wb_req_t               out_q, out_d;
   logic                  regwr_q, regwr_d;
   logic                  alu_gnt, lsu_gnt;
   logic                  acc_vld;
   wb_req_t               acc;
   logic                  clr_vld;
   logic [REG_ADDR_W-1:0] clr_rd;

   // On a tie the requester that did not win last time is granted.
   assign alu_gnt = bus.alu_valid && (!bus.lsu_valid || (last_q == WB_LSU));
   assign lsu_gnt = bus.lsu_valid && (!bus.alu_valid || (last_q == WB_ALU));

   always_comb begin
      acc_vld = alu_gnt || lsu_gnt;
      acc     = lsu_gnt ? '{rd: bus.lsu_rd, dat: bus.lsu_data}
                        : '{rd: bus.alu_rd, dat: bus.alu_data};
      last_d  = last_q;
      if (alu_gnt) begin
         last_d = WB_ALU;
      end else if (lsu_gnt) begin
         last_d = WB_LSU;
      end
      out_d   = acc_vld ? acc : out_q;
      regwr_d = acc_vld && (acc.rd != '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_q  <= WB_LSU;
         out_q   <= '0;
         regwr_q <= 1'b0;
      end else begin
         last_q  <= last_d;
         out_q   <= out_d;
         regwr_q <= regwr_d;
      end
   end

`ifdef RF_WB_BYPASS_EN
   // Forwarding covers the rf_regwr cycle, so the busy bit can drop at acceptance.
   assign clr_vld = acc_vld;
   assign clr_rd  = acc.rd;

   assign bus.opa = (regwr_q && (out_q.rd == bus.rs1) && (bus.rs1 != '0)) ? out_q.dat : bus.rf_busa_in;
   assign bus.opb = (regwr_q && (out_q.rd == bus.rs2) && (bus.rs2 != '0)) ? out_q.dat : bus.rf_busb_in;
`else
   assign clr_vld = regwr_q;
   assign clr_rd  = out_q.rd;
`endif

   rf_scoreboard u_sb (
      .clk       (clk),
      .rst_n     (rst_n),
      .iss_valid (bus.iss_valid),
      .iss_rd    (bus.iss_rd),
      .iss_ready (bus.iss_ready),
      .clr_vld   (clr_vld),
      .clr_rd    (clr_rd),
      .rs1       (bus.rs1),
      .rs2       (bus.rs2),
      .rs1_busy  (bus.rs1_busy),
      .rs2_busy  (bus.rs2_busy),
      .busy_mask (bus.busy_mask),
      .wb_err    (bus.wb_err)
   );

   assign bus.alu_ready = alu_gnt;
   assign bus.lsu_ready = lsu_gnt;
   assign bus.rf_regwr  = regwr_q;
   assign bus.rf_rd     = out_q.rd;
   assign bus.rf_busw   = out_q.dat;

endmodule

// File: doc/rf_wb_sched.md
# rf_wb_sched

Write-back scheduler and scoreboard for the 32 x 32-bit, 2-read/1-write register file. It shares the single write port between two producers, the ALU path and the variable-latency load/store unit, using round-robin arbitration with valid/ready handshakes. It tracks pending destinations in a busy mask so issue logic can detect RAW and WAW hazards. It sits between the execute/memory stages and the register file's write port.

## Interface
- XLEN, 32, data width
- NREG, 32, number of architectural registers; x0 is hard-wired zero
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- iss_valid  in  1  an instruction that writes iss_rd is issuing
- iss_rd  in  5  destination of the issuing instruction
- iss_ready  out  1  issue permitted; low if iss_rd != 0 and busy_mask[iss_rd] = 1 (WAW stall)
- alu_valid / alu_ready  in / out  1  ALU write-back handshake
- alu_rd, alu_data  in  5, XLEN  ALU destination and result
- lsu_valid / lsu_ready  in / out  1  LSU write-back handshake
- lsu_rd, lsu_data  in  5, XLEN  LSU destination and load data
- rf_regwr, rf_rd, rf_busw  out  1, 5, XLEN  registered drive to the register-file write port
- rs1, rs2  in  5  source registers of the instruction in decode
- rs1_busy, rs2_busy  out  1  the source has a pending write; always 0 for x0
- busy_mask  out  NREG  scoreboard contents; bit 0 is always 0
- wb_err  out  1  sticky; a write-back targeted a non-busy register other than x0

## Operation
- Arbitration:
  - Only one requester valid: it gets ready = 1.
  - Both valid: the requester not granted last wins.
  - The last-grant pointer updates only on an accepted transfer.
  - ready is combinational from the valids and the pointer. A requester may not drop valid until accepted.
- Acceptance is valid & ready at a rising edge.
  - The accepted rd/data are registered into rf_rd/rf_busw, and rf_regwr = 1 for exactly the next cycle.
  - rd = 0 completes the handshake but leaves rf_regwr = 0.
- Scoreboard set: iss_valid & iss_ready & iss_rd != 0 sets busy_mask[iss_rd] at the edge.
- Scoreboard clear: timing depends on the configuration (see below). A set and a clear of different registers in the same cycle are independent.
- Same-register set and clear cannot collide: iss_ready is computed from the pre-clear mask, so issue stalls for one cycle.
- A write-back to a non-busy register (not x0) is still written, and wb_err sets. wb_err clears only on reset.
- rsN_busy = busy_mask[rsN], combinational.
- Reset mid-operation drops all in-flight transfers. Producers must re-issue after reset.

## Timing
- Reset values:
  - busy_mask = 0, rf_regwr = 0, rf_rd = 0, rf_busw = 0, wb_err = 0.
  - Pointer state is "LSU granted last", so the ALU wins the first tie.
- Latency from acceptance to register-file write: 2 edges.
  - Edge N: accepted into the output registers.
  - Edge N+1: the register file captures rf_busw.
- Throughput: one write per cycle. The losing requester waits at least one cycle.
- The iss_ready, rsN_busy and ready paths are combinational. All other outputs are registered.

## Configuration
- RF_WB_BYPASS_EN defined:
  - Ports rf_busa_in, rf_busb_in (in, XLEN) and opa, opb (out, XLEN) are added.
  - opa = rf_busw when rf_regwr & rf_rd == rs1 & rs1 != 0, else rf_busa_in. opb is the same using rs2 and rf_busb_in.
  - The busy bit clears at the acceptance edge N, so a consumer reading during the rf_regwr cycle gets forwarded data.
- RF_WB_BYPASS_EN undefined:
  - No bypass ports.
  - The busy bit clears at edge N+1, when the register file is actually written.
  - rsN_busy therefore stays high one cycle longer.

## Structure
- Shared package rf_pkg holds:
  - XLEN, NREG, REG_ADDR_W = 5
  - a wb_src_t enum {WB_ALU, WB_LSU} used for the grant pointer
- Sub-module rf_scoreboard holds the busy mask, the set/clear logic, the iss_ready and rsN_busy lookups, and wb_err.
- The top level holds the arbiter, the output registers and the optional bypass mux.

## Test plan
- Reset, then ALU-only: issue rd = 5; alu_rd = 5, data 0x1234 accepted at edge N -> rf_regwr = 1 with rf_rd = 5 and rf_busw = 0x1234 in cycle N+1. busy_mask[5] clears at edge N (bypass) or edge N+1 (no bypass).
- Both valid for 4 cycles, rds 3 and 4 -> grants alternate ALU, LSU, ALU, LSU starting with ALU. rf_rd sequence is 3, 4, 3, 4.
- Issue rd = 7 twice back-to-back -> second issue has iss_ready = 0 until rd 7 is written back. rs1 = 7 gives rs1_busy = 1 throughout.
- Write-back with rd = 0, data 0xFFFF_FFFF -> handshake completes, rf_regwr stays 0, busy_mask unchanged, wb_err = 0.
- Write-back to non-busy rd = 9 -> rf_regwr = 1 for rd 9 and wb_err sets and stays high. Assert rst_n low mid-burst -> all outputs return to reset values immediately.
- Bypass build: rs1 = 6 while rf_regwr = 1, rf_rd = 6, rf_busw = 0xABCD -> opa = 0xABCD. With rs1 = 0 in the same situation, opa = rf_busa_in.
